// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle between a ratio source and the divider controller.
// master drives run/config requests; slave (the controller) returns status.
interface clk_div_ctrl_if #(
  parameter int DIV_W = 4
);
  logic             enable;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output enable, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, tick, busy, cur_div
  );

  modport slave (
    input  enable, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, tick, busy, cur_div
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free run-time divide-by-N controller: start/stop/ratio change only on period boundaries.
// All outputs registered; start takes effect on the sampling edge; a pending ratio stalls cfg_valid.
module clk_div_ctrl #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic last_cyc;
  logic apply;
  logic accept;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    cfg_err_d    = 1'b0;

    last_cyc = (cnt_q == cur_div_q - ONE);
    apply    = pend_valid_q && ((state_q == IDLE) || last_cyc);
    accept   = bus.cfg_valid && !pend_valid_q;

    if (apply) begin
      cur_div_d    = pend_div_q;
      pend_valid_d = 1'b0;
    end

    // accept and apply are mutually exclusive: accept needs an empty slot
    if (accept) begin
      if (bus.cfg_div >= TWO) begin
        pend_div_d   = bus.cfg_div;
        pend_valid_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable) state_d = RUN;
      end
      default: begin
        // RUN and STOP count identically; enable only decides where the period lands
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = bus.enable ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = bus.enable ? RUN : STOP;
        end
      end
    endcase

    clk_out_d = (state_d != IDLE) && (cnt_d < (cur_div_d >> 1));
    tick_d    = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DIV_RST;
      pend_div_q   <= DIV_RST;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.cfg_ready = !pend_valid_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: table of per-edge vectors plus hand-written reset sequences.
module tb_clk_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.DIV_W(4)) bus ();

  clk_div_ctrl #(.DIV_W(4), .DEFAULT_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       en;
    logic       cv;
    logic [3:0] cd;
    logic       e_clk;
    logic       e_tick;
    logic       e_busy;
    logic       e_rdy;
    logic       e_err;
    logic [3:0] e_div;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic en, input logic cv, input logic [3:0] cd,
                              input logic c, input logic t, input logic b,
                              input logic r, input logic e, input logic [3:0] d);
    vec_t v;
    v.en = en; v.cv = cv; v.cd = cd;
    v.e_clk = c; v.e_tick = t; v.e_busy = b; v.e_rdy = r; v.e_err = e; v.e_div = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic t, input logic b,
                            input logic r, input logic e, input logic [3:0] d);
    chk($sformatf("%s clk_out", tag),   8'(bus.clk_out),   8'(c));
    chk($sformatf("%s tick", tag),      8'(bus.tick),      8'(t));
    chk($sformatf("%s busy", tag),      8'(bus.busy),      8'(b));
    chk($sformatf("%s cfg_ready", tag), 8'(bus.cfg_ready), 8'(r));
    chk($sformatf("%s cfg_err", tag),   8'(bus.cfg_err),   8'(e));
    chk($sformatf("%s cur_div", tag),   8'(bus.cur_div),   8'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              en cv cd  clk tk bz rdy err div
    // default N=3 run
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 3));
    // offer 4 at cnt=1: current period completes, then 1,1,0,0
    tbl.push_back(mk(1, 1, 4,  0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 4));
    // 7 accepted, 5 stalled until ready, then applied a period later
    tbl.push_back(mk(1, 1, 7,  1, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 5,  0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 5,  0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 5,  1, 1, 1, 1, 0, 7));
    tbl.push_back(mk(1, 1, 5,  1, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 5));
    // illegal ratio 1: one-cycle error pulse, ratio unchanged
    tbl.push_back(mk(1, 1, 1,  1, 0, 1, 1, 1, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 5));
    // switch to N=4
    tbl.push_back(mk(1, 1, 4,  1, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 4));
    // drop enable at cnt=0: finish 1,1,0,0 then IDLE
    tbl.push_back(mk(0, 0, 0,  1, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 4));
    // restart, drop, re-raise at cnt=2: no gap
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  1, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 4));
    // back to N=3
    tbl.push_back(mk(1, 1, 3,  0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 3));
    // pending 6 and enable drop collide at the last cycle
    tbl.push_back(mk(1, 1, 6,  0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 6));

    rst = 1'b0;
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 4'd0;
    #1 rst = 1'b1;
    #2;
    check_outs("reset_initial", 0, 0, 0, 1, 0, 4'd3);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.enable    = tbl[i].en;
      bus.cfg_valid = tbl[i].cv;
      bus.cfg_div   = tbl[i].cd;
      step();
      check_outs($sformatf("row%0d", i), tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_busy,
                 tbl[i].e_rdy, tbl[i].e_err, tbl[i].e_div);
    end

    // reset mid-cycle while running with a ratio pending: all cleared without an edge
    bus.enable    = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd9;
    step();
    chk("pend_before_reset cfg_ready", 8'(bus.cfg_ready), 8'd0);
    bus.cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outs("reset_midcycle", 0, 0, 0, 1, 0, 4'd3);
    step();
    step();
    rst = 1'b0;

    // restart after reset: default ratio, discarded pending 9 never appears
    step();
    check_outs("post_reset_p0", 1, 1, 1, 1, 0, 4'd3);
    step();
    check_outs("post_reset_p1", 0, 0, 1, 1, 0, 4'd3);
    step();
    check_outs("post_reset_p2", 0, 0, 1, 1, 0, 4'd3);
    step();
    check_outs("post_reset_p3", 1, 1, 1, 1, 0, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
